// File: rtl/j1_io_pkg.sv
// Shared definitions for the j1 I/O bus slaves.
// Address map, UART status bit positions, RX FSM states.
package j1_io_pkg;

  localparam logic [15:0] IO_UART_DATA = 16'h1000;
  localparam logic [15:0] IO_UART_STAT = 16'h2000;

  localparam int ST_TX_RDY   = 0;
  localparam int ST_RX_AVAIL = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_RX_FERR  = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and the j1 I/O bus.
// Pushes into a full FIFO and pops from an empty one are ignored.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/j1_uart_io.sv
// j1 I/O-bus UART: registered bus decode, TX holding register
// plus shifter, 2-flop synchronised RX sampler feeding a FIFO.
module j1_uart_io
  import j1_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int RX_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rd_q, wr_q;
  logic [15:0] addr_q, data_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      rd_q   <= io_rd;
      wr_q   <= io_wr;
      addr_q <= mem_addr;
      data_q <= dout;
    end
  end

  logic sel_data, sel_stat;
  logic wr_data, rd_data, rd_stat;

  assign sel_data = (addr_q[15:12] == IO_UART_DATA[15:12]);
  assign sel_stat = (addr_q[15:12] == IO_UART_STAT[15:12]);
  assign wr_data  = wr_q && sel_data;
  assign rd_data  = rd_q && sel_data;
  assign rd_stat  = rd_q && sel_stat;

  logic        hold_full;
  logic [7:0]  hold_byte;
  logic        tx_busy, tx_q;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_idx;
  logic [7:0]  tx_sr;
  logic        tx_bit_end, tx_frame_end, tx_take;

  assign tx_bit_end   = tx_busy && (tx_cnt == BIT_LAST);
  assign tx_frame_end = tx_bit_end && (tx_idx == 4'd9);
  assign tx_take      = hold_full && (!tx_busy || tx_frame_end);
  assign uart_tx      = tx_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      hold_full <= 1'b0;
      hold_byte <= '0;
    end else begin
      if (tx_take) hold_full <= 1'b0;
      if (wr_data && !hold_full) begin
        hold_full <= 1'b1;
        hold_byte <= data_q[7:0];
      end
    end
  end

  // Stop bit falls out of the shifter by back-filling ones.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_busy <= 1'b0;
      tx_q    <= 1'b1;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sr   <= '0;
    end else if (tx_take) begin
      tx_busy <= 1'b1;
      tx_q    <= 1'b0;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sr   <= hold_byte;
    end else if (!tx_busy || tx_frame_end) begin
      tx_busy <= 1'b0;
      tx_q    <= 1'b1;
      tx_cnt  <= '0;
    end else if (tx_bit_end) begin
      tx_cnt  <= '0;
      tx_idx  <= tx_idx + 4'd1;
      tx_q    <= tx_sr[0];
      tx_sr   <= {1'b1, tx_sr[7:1]};
    end else begin
      tx_cnt  <= tx_cnt + 16'd1;
    end
  end

  logic        rx_s1, rx_s2, rx_s3;
  rx_state_e   rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sr;
  logic        rx_fall, rx_half, rx_full;
  logic        rx_shift, rx_push, rx_ferr;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 && !rx_s2;
  assign rx_half = (rx_state == RX_START) && (rx_cnt == HALF_LAST);
  assign rx_full = ((rx_state == RX_DATA) || (rx_state == RX_STOP))
                   && (rx_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_full && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_shift = 1'b0;
    rx_push  = 1'b0;
    rx_ferr  = 1'b0;
    unique case (rx_state)
      RX_DATA: rx_shift = rx_full;
      RX_STOP: begin
        rx_push = rx_full && rx_s2;
        rx_ferr = rx_full && !rx_s2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sr  <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_half || rx_full) rx_cnt <= '0;
      else                                           rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == RX_START) rx_idx <= '0;
      else if (rx_shift)        rx_idx <= rx_idx + 3'd1;
      if (rx_shift) rx_sr <= {rx_s2, rx_sr[7:1]};
    end
  end

  logic [7:0]  fifo_rdata;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;

  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (rx_push),
    .pop    (rd_data),
    .wdata  (rx_sr),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  logic ovr_q, ferr_q;

  // A new event on the clearing edge wins over the clear.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (rx_push && fifo_full) ovr_q <= 1'b1;
      else if (rd_stat)         ovr_q <= 1'b0;
      if (rx_ferr)              ferr_q <= 1'b1;
      else if (rd_stat)         ferr_q <= 1'b0;
    end
  end

  logic [15:0] status;

  always_comb begin
    status              = '0;
    status[ST_TX_RDY]   = !hold_full;
    status[ST_RX_AVAIL] = !fifo_empty;
    status[ST_RX_OVR]   = ovr_q;
    status[ST_RX_FERR]  = ferr_q;
  end

  always_comb begin
    io_din = '0;
    unique case (1'b1)
      sel_data: io_din = {8'h00, fifo_empty ? 8'h00 : fifo_rdata};
      sel_stat: io_din = status;
      default:  io_din = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{addr_q[11:0], data_q[15:8], fifo_count};

endmodule
